// File: rtl/pss_pkg.sv
// rtl/pss_pkg.sv - shared types and helpers for the PSS peak detector
package pss_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    REPORT = 2'd2
  } peak_state_t;

  // Width at which the scaled magnitude and scaled sum are compared without truncation.
  function automatic int cmp_width(input int in_dw, input int avg_log2, input int detect_shift);
    return in_dw + avg_log2 + detect_shift;
  endfunction

endpackage

// File: rtl/moving_sum.sv
// rtl/moving_sum.sv - running sum of the 2**LOG2 most recent accepted samples
module moving_sum
  import pss_pkg::*;
#(
  parameter int DW   = 24,
  parameter int LOG2 = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               valid_i,
  input  logic [DW-1:0]      data_i,
  output logic [DW+LOG2-1:0] sum_o
);

  localparam int DEPTH = 2 ** LOG2;
  localparam int SW    = DW + LOG2;

  logic [DW-1:0] dly_q [DEPTH];
  logic [SW-1:0] sum_q;

  // sum_q excludes the sample currently on data_i; it joins on the accepting edge.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
      sum_q <= '0;
    end else if (valid_i) begin
      dly_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) dly_q[i] <= dly_q[i-1];
      sum_q <= sum_q + SW'(data_i) - SW'(dly_q[DEPTH-1]);
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/pss_peak_detector.sv
// rtl/pss_peak_detector.sv - threshold crossing, windowed max search and peak report
module pss_peak_detector
  import pss_pkg::*;
#(
  parameter int IN_DW        = 24,
  parameter int C_DW         = 80,
  parameter int AVG_LOG2     = 4,
  parameter int DETECT_SHIFT = 2,
  parameter int WINDOW_LEN   = 8,
  parameter int CNT_DW       = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [IN_DW-1:0]  s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  input  logic [C_DW-1:0]   C0_i,
  input  logic [C_DW-1:0]   C1_i,
  input  logic [IN_DW-1:0]  noise_floor_i,
  output logic              peak_valid_o,
  output logic [IN_DW-1:0]  peak_mag_o,
  output logic [CNT_DW-1:0] peak_idx_o,
  output logic [C_DW-1:0]   peak_C0_o,
  output logic [C_DW-1:0]   peak_C1_o,
  output logic              busy_o
);

  localparam int CW = cmp_width(IN_DW, AVG_LOG2, DETECT_SHIFT);
  localparam int SW = IN_DW + AVG_LOG2;
  localparam int FW = AVG_LOG2 + 1;
  localparam logic [FW-1:0] FILL_FULL = FW'(2 ** AVG_LOG2);
  localparam int WW = $clog2(WINDOW_LEN + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_LEN - 1);

  peak_state_t       state_q;
  logic [SW-1:0]     sum;
  logic [CW-1:0]     x_scaled;
  logic [CW-1:0]     s_scaled;
  logic              warm;
  logic              crossing;
  logic              take_max;
  logic              win_done;
  logic [FW-1:0]     fill_q;
  logic [CNT_DW-1:0] idx_q;
  logic [WW-1:0]     win_cnt_q;
  logic [IN_DW-1:0]  max_q;
  logic [CNT_DW-1:0] max_idx_q;
  logic [C_DW-1:0]   max_c0_q;
  logic [C_DW-1:0]   max_c1_q;

  moving_sum #(
    .DW   (IN_DW),
    .LOG2 (AVG_LOG2)
  ) u_moving_sum (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .valid_i  (s_axis_in_tvalid),
    .data_i   (s_axis_in_tdata),
    .sum_o    (sum)
  );

  // Outside SEARCH (including the REPORT cycle) a sample is judged as a fresh crossing.
  always_comb begin
    x_scaled = CW'(s_axis_in_tdata) << AVG_LOG2;
    s_scaled = CW'(sum) << DETECT_SHIFT;
    warm     = (fill_q == FILL_FULL);
    crossing = warm && (x_scaled > s_scaled) && (s_axis_in_tdata > noise_floor_i);
    take_max = (state_q == SEARCH) ? (s_axis_in_tdata > max_q) : crossing;
    win_done = (state_q == SEARCH) ? (win_cnt_q == WIN_LAST) : (crossing && (WINDOW_LEN == 1));
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      fill_q       <= '0;
      idx_q        <= '0;
      win_cnt_q    <= '0;
      max_q        <= '0;
      max_idx_q    <= '0;
      max_c0_q     <= '0;
      max_c1_q     <= '0;
      peak_valid_o <= 1'b0;
      peak_mag_o   <= '0;
      peak_idx_o   <= '0;
      peak_C0_o    <= '0;
      peak_C1_o    <= '0;
    end else begin
      peak_valid_o <= 1'b0;
      if (state_q == REPORT) state_q <= IDLE;
      if (s_axis_in_tvalid) begin
        idx_q <= idx_q + 1'b1;
        if (!warm) fill_q <= fill_q + 1'b1;
        if (take_max) begin
          max_q     <= s_axis_in_tdata;
          max_idx_q <= idx_q;
          max_c0_q  <= C0_i;
          max_c1_q  <= C1_i;
        end
        if (state_q == SEARCH) begin
          win_cnt_q <= win_cnt_q + 1'b1;
        end else if (crossing) begin
          win_cnt_q <= WW'(1);
          state_q   <= SEARCH;
        end
        // The closing sample may itself be the new maximum, so forward it directly.
        if (win_done) begin
          state_q      <= REPORT;
          peak_valid_o <= 1'b1;
          peak_mag_o   <= take_max ? s_axis_in_tdata : max_q;
          peak_idx_o   <= take_max ? idx_q : max_idx_q;
          peak_C0_o    <= take_max ? C0_i : max_c0_q;
          peak_C1_o    <= take_max ? C1_i : max_c1_q;
        end
      end
    end
  end

  assign busy_o = (state_q == SEARCH);

endmodule
